// File: rtl/pixel_plot_sink.sv
// rtl/pixel_plot_sink.sv - sprite pixel stream sink with FIFO, clip/key filter and framebuffer write port
//
// Purpose:
//   Buffers (x, y, colour, last) beats from a sprite drawer in a small FIFO,
//   drops pixels that fall off-screen or match the transparent key colour,
//   and writes the remaining pixels to the 320x240x3 framebuffer port.
//   Drawers are stalled through in_ready while the display side holds the port.
//
// Ports:
//   clock_all      in   1   rising-edge clock
//   reset_all      in   1   asynchronous active-high reset
//   in_valid       in   1   drawer presents a pixel
//   in_ready       out  1   sink can accept (FIFO not full)
//   in_x           in   9   screen x
//   in_y           in   8   screen y
//   in_colour      in   3   pixel colour
//   in_last        in   1   final pixel of current sprite
//   fb_hold        in   1   framebuffer port busy, no write may issue
//   fb_wren        out  1   write strobe
//   fb_address     out  17  y*SCREEN_W + x
//   fb_data        out  3   colour written
//   sprite_done    out  1   pulse when a last-pixel retires
//   written_count  out  17  pixels written since reset (wraps)
//   dropped_count  out  17  pixels clipped/transparent since reset (wraps)
//   fifo_level     out  5   current FIFO occupancy
module pixel_plot_sink #(
  parameter int         FIFO_DEPTH         = 4,
  parameter int         SCREEN_W           = 320,
  parameter int         SCREEN_H           = 240,
  parameter bit         TRANSPARENT_EN     = 1'b0,
  parameter logic [2:0] TRANSPARENT_COLOUR = 3'b000
) (
  input  logic        clock_all,
  input  logic        reset_all,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_x,
  input  logic [7:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_last,
  input  logic        fb_hold,
  output logic        fb_wren,
  output logic [16:0] fb_address,
  output logic [2:0]  fb_data,
  output logic        sprite_done,
  output logic [16:0] written_count,
  output logic [16:0] dropped_count,
  output logic [4:0]  fifo_level
);

  localparam int         AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

  // Entry layout: {x[8:0], y[7:0], colour[2:0], last}
  logic [20:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;

  logic          push;
  logic          pop;
  logic [20:0]   head;
  logic [8:0]    head_x;
  logic [7:0]    head_y;
  logic [2:0]    head_colour;
  logic          head_last;
  logic          drop;
  logic [16:0]   addr_calc;

  // Full check uses the count alone, so a same-cycle pop never frees a slot
  // for a push; this keeps in_ready independent of fb_hold and in_valid.
  assign in_ready   = (count != DEPTH5);
  assign fifo_level = count;
  assign push       = in_valid && in_ready;
  assign pop        = (count != 5'd0) && !fb_hold;

  assign head        = mem[rd_ptr];
  assign head_x      = head[20:12];
  assign head_y      = head[11:4];
  assign head_colour = head[3:1];
  assign head_last   = head[0];

  always_comb begin
    drop = 1'b0;
    if ({23'b0, head_x} >= 32'(SCREEN_W)) drop = 1'b1;
    if ({24'b0, head_y} >= 32'(SCREEN_H)) drop = 1'b1;
    if (TRANSPARENT_EN && (head_colour == TRANSPARENT_COLOUR)) drop = 1'b1;
  end

  assign addr_calc = 17'(head_y) * 17'(SCREEN_W) + 17'(head_x);

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clock_all) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_colour, in_last};
  end

  always_ff @(posedge clock_all or posedge reset_all) begin
    if (reset_all) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_all or posedge reset_all) begin
    if (reset_all) begin
      fb_wren       <= 1'b0;
      fb_address    <= 17'd0;
      fb_data       <= 3'd0;
      sprite_done   <= 1'b0;
      written_count <= 17'd0;
      dropped_count <= 17'd0;
    end else begin
      fb_wren     <= pop && !drop;
      sprite_done <= pop && head_last;
      if (pop) begin
        if (drop) begin
          dropped_count <= dropped_count + 17'd1;
        end else begin
          fb_address    <= addr_calc;
          fb_data       <= head_colour;
          written_count <= written_count + 17'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_plot_sink.sv
// tb/tb_pixel_plot_sink.sv - scoreboard bench for pixel_plot_sink
module tb_pixel_plot_sink;

  logic        clock_all = 1'b0;
  logic        reset_all;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_x;
  logic [7:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_last;
  logic        fb_hold;
  logic        fb_wren;
  logic [16:0] fb_address;
  logic [2:0]  fb_data;
  logic        sprite_done;
  logic [16:0] written_count;
  logic [16:0] dropped_count;
  logic [4:0]  fifo_level;

  pixel_plot_sink #(
    .FIFO_DEPTH(4),
    .SCREEN_W(320),
    .SCREEN_H(240),
    .TRANSPARENT_EN(1'b1),
    .TRANSPARENT_COLOUR(3'b000)
  ) dut (
    .clock_all(clock_all),
    .reset_all(reset_all),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_y(in_y),
    .in_colour(in_colour),
    .in_last(in_last),
    .fb_hold(fb_hold),
    .fb_wren(fb_wren),
    .fb_address(fb_address),
    .fb_data(fb_data),
    .sprite_done(sprite_done),
    .written_count(written_count),
    .dropped_count(dropped_count),
    .fifo_level(fifo_level)
  );

  always #5 clock_all = ~clock_all;

  typedef struct {
    bit wren;
    int addr;
    int data;
    bit done;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [16:0] exp_written = '0;
  logic [16:0] exp_dropped = '0;
  int          done_seen = 0;
  int          wr_seen = 0;
  bit          ready_low = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: every observable retirement pops one expected record.
  always @(negedge clock_all) begin
    if (!reset_all && (fb_wren || sprite_done)) begin
      if (fb_wren) wr_seen++;
      if (sprite_done) done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(fb_wren), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_wren", 32'(fb_wren), 32'(e.wren));
        if (e.wren) begin
          check("sb_addr", 32'(fb_address), 32'(e.addr));
          check("sb_data", 32'(fb_data), 32'(e.data));
        end
        check("sb_done", 32'(sprite_done), 32'(e.done));
      end
    end
  end

  task automatic model_push(input int x, input int y, input int c, input bit l);
    bit   drop;
    exp_t e;
    drop = (x >= 320) || (y >= 240) || (c == 0);
    if (drop) exp_dropped = exp_dropped + 17'd1;
    else      exp_written = exp_written + 17'd1;
    if (!drop || l) begin
      e.wren = !drop;
      e.addr = y * 320 + x;
      e.data = c;
      e.done = l;
      exp_q.push_back(e);
    end
  endtask

  // Drives one beat starting just after a rising edge; returns whether it was taken.
  task automatic send(input int x, input int y, input int c, input bit l,
                      input bit retry, output bit acc);
    int tries;
    tries = 0;
    acc = 0;
    in_x = 9'(x);
    in_y = 8'(y);
    in_colour = 3'(c);
    in_last = l;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      if (!in_ready) ready_low = 1;
      @(posedge clock_all);
      #1;
      tries++;
    end while (!acc && retry && tries < 100);
    in_valid = 1'b0;
    if (acc) model_push(x, y, c, l);
    if (retry && !acc) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_level != 5'd0) && n < 500) begin
      @(posedge clock_all);
      #1;
      n++;
    end
    check("drain_bound", 32'(n < 500), 32'(1));
    repeat (2) begin
      @(posedge clock_all);
      #1;
    end
  endtask

  initial begin
    bit acc;
    int accepted;

    reset_all = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_colour = '0;
    in_last = 1'b0;
    fb_hold = 1'b0;
    repeat (2) @(posedge clock_all);
    #1;
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(1));
    check("rst_wren", 32'(fb_wren), 32'(0));
    check("rst_addr", 32'(fb_address), 32'(0));
    check("rst_data", 32'(fb_data), 32'(0));
    check("rst_done", 32'(sprite_done), 32'(0));
    check("rst_written", 32'(written_count), 32'(0));
    check("rst_dropped", 32'(dropped_count), 32'(0));
    @(negedge clock_all);
    reset_all = 1'b0;
    @(posedge clock_all);
    #1;

    // Single pixel and its latency
    send(10, 5, 5, 1'b1, 1'b1, acc);
    @(negedge clock_all);
    check("lat_wren_early", 32'(fb_wren), 32'(0));
    @(negedge clock_all);
    check("single_wren", 32'(fb_wren), 32'(1));
    check("single_addr", 32'(fb_address), 32'(1610));
    check("single_data", 32'(fb_data), 32'(5));
    check("single_done", 32'(sprite_done), 32'(1));
    @(posedge clock_all);
    #1;
    check("single_written", 32'(written_count), 32'(1));
    drain();

    // 53x57 stream, full rate
    ready_low = 0;
    done_seen = 0;
    for (int yy = 0; yy < 57; yy++) begin
      for (int xx = 0; xx < 53; xx++) begin
        send(52 + xx, 56 + yy, ((yy * 53 + xx) % 7) + 1, (yy == 56) && (xx == 52), 1'b1, acc);
      end
    end
    drain();
    check("stream_ready_low", 32'(ready_low), 32'(0));
    check("stream_done_count", 32'(done_seen), 32'(1));
    check("stream_written", 32'(written_count), 32'(exp_written));

    // Clipping boundaries
    send(320, 0, 2, 1'b0, 1'b1, acc);
    send(0, 240, 2, 1'b0, 1'b1, acc);
    send(319, 239, 6, 1'b0, 1'b1, acc);
    drain();
    check("clip_dropped", 32'(dropped_count), 32'(2));
    check("clip_dropped_model", 32'(dropped_count), 32'(exp_dropped));
    check("clip_written", 32'(written_count), 32'(exp_written));

    // Transparent key, last on the dropped entry
    done_seen = 0;
    send(1, 1, 0, 1'b1, 1'b1, acc);
    send(2, 1, 3, 1'b0, 1'b1, acc);
    drain();
    check("key_done", 32'(done_seen), 32'(1));
    check("key_dropped", 32'(dropped_count), 32'(3));
    check("key_written", 32'(written_count), 32'(exp_written));

    // Backpressure
    fb_hold = 1'b1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      send(100 + i, 7, 4, 1'b0, 1'b0, acc);
      if (acc) accepted++;
    end
    check("bp_accepted", 32'(accepted), 32'(4));
    check("bp_ready", 32'(in_ready), 32'(0));
    check("bp_level", 32'(fifo_level), 32'(4));
    check("bp_wren_held", 32'(fb_wren), 32'(0));
    fb_hold = 1'b0;
    @(posedge clock_all);
    #1;
    check("bp_ready_rise", 32'(in_ready), 32'(1));
    check("bp_level_after_pop", 32'(fifo_level), 32'(3));
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_all);
      check("bp_consecutive_wren", 32'(fb_wren), 32'(1));
    end
    @(negedge clock_all);
    check("bp_wren_end", 32'(fb_wren), 32'(0));
    drain();

    // Reset with entries buffered
    @(posedge clock_all);
    #1;
    fb_hold = 1'b1;
    for (int i = 0; i < 3; i++) send(20 + i, 9, 1, 1'b1, 1'b1, acc);
    check("rst_mid_level_pre", 32'(fifo_level), 32'(3));
    #2;
    reset_all = 1'b1;
    #1;
    check("rst_mid_level", 32'(fifo_level), 32'(0));
    check("rst_mid_ready", 32'(in_ready), 32'(1));
    check("rst_mid_wren", 32'(fb_wren), 32'(0));
    check("rst_mid_written", 32'(written_count), 32'(0));
    check("rst_mid_dropped", 32'(dropped_count), 32'(0));
    exp_q.delete();
    exp_written = '0;
    exp_dropped = '0;
    wr_seen = 0;
    done_seen = 0;
    fb_hold = 1'b0;
    @(negedge clock_all);
    reset_all = 1'b0;
    repeat (6) @(posedge clock_all);
    #1;
    check("post_rst_writes", 32'(wr_seen), 32'(0));
    check("post_rst_done", 32'(done_seen), 32'(0));
    check("post_rst_written", 32'(written_count), 32'(0));
    check("post_rst_level", 32'(fifo_level), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_plot_sink.md
# pixel_plot_sink

Receiving end of the sprite pixel stream. Accepts (x, y, colour, last) beats from a sprite drawer through a valid/ready handshake and buffers them in a small FIFO. Clips and filters each pixel, then writes the survivors into the 320x240, 3-bit-colour framebuffer RAM port. Sits between the sprite drawers and the framebuffer, so drawers no longer drive the framebuffer directly and can be stalled while the display side owns the port.

## Interface

Parameters:
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16
- SCREEN_W, 320, columns; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 240, rows; pixels with y >= SCREEN_H are clipped
- TRANSPARENT_EN, 0, when 1, pixels equal to TRANSPARENT_COLOUR are dropped
- TRANSPARENT_COLOUR, 3'b000, key colour

Ports:
- clock_all  in  1  single clock, rising edge
- reset_all  in  1  asynchronous, active-high reset
- in_valid  in  1  drawer presents a pixel
- in_ready  out  1  sink can accept; equals !fifo_full
- in_x  in  9  screen x
- in_y  in  8  screen y
- in_colour  in  3  pixel colour
- in_last  in  1  final pixel of the current sprite
- fb_hold  in  1  framebuffer port busy; no write may issue
- fb_wren  out  1  write strobe, one word per cycle
- fb_address  out  17  y*SCREEN_W + x
- fb_data  out  3  colour written
- sprite_done  out  1  one-cycle pulse after a last-pixel retires
- written_count  out  17  pixels written since reset, wraps
- dropped_count  out  17  pixels clipped or transparent since reset, wraps
- fifo_level  out  5  current occupancy

## Operation

- Push occurs on a clock edge with in_valid & in_ready. The entry stores {x, y, colour, last}.
- in_ready is low only when the FIFO is full. There is no push-while-full, even if a pop happens in the same cycle.
- Pop occurs when the FIFO is non-empty and fb_hold is 0; at most one pop per cycle. Push and pop in the same cycle leave fifo_level unchanged.
- Each popped entry is retired in exactly one of two ways:
  - Clip or transparent: when x >= SCREEN_W, or y >= SCREEN_H, or (TRANSPARENT_EN and colour == TRANSPARENT_COLOUR), the entry is dropped. No write issues and dropped_count is incremented.
  - Otherwise: registered outputs are fb_wren=1, fb_address = (y<<8)+(y<<6)+x (17-bit, no overflow for in-range pixels), fb_data=colour. written_count is incremented.
- If the entry had last=1, sprite_done pulses on the same registered cycle as its write/drop outputs, whether the entry was written or dropped.
- Counters wrap 17'h1FFFF -> 0.
- Order is strict FIFO. Pixels are never reordered, merged or duplicated.
- While fb_hold=1 the FIFO only fills; once full, in_ready drops.

## Timing

- Reset (async assert, sampled deassert): FIFO empty, fifo_level=0, in_ready=1, fb_wren=0, fb_address=0, fb_data=0, sprite_done=0, both counters 0.
- Latency: a pixel pushed at edge N into an empty FIFO, with fb_hold=0, is popped at edge N+1. Its fb_wren/fb_address/fb_data/sprite_done are valid during cycle N+1→N+2.
- Throughput: one pixel per cycle sustained with fb_hold=0. in_ready stays high throughout.
- fb_hold is sampled at the pop edge. If fb_hold=1 at edge M, fb_wren=0 during the following cycle.
- fb_wren and sprite_done are single-cycle per entry and deassert when no pop occurred at the prior edge.
- in_ready is combinational from the FIFO count only, never from in_valid or fb_hold.
- Reset mid-stream discards all buffered entries. No write or sprite_done is emitted for them.

## Test plan

- Single pixel (x=10, y=5, colour=3'b101, last=1) → fb_wren=1, fb_address=1610, fb_data=5, sprite_done=1, all in the same cycle, 1 cycle after the push; written_count=1.
- 53x57 stream (3021 pixels, last on the final beat), fb_hold=0 → in_ready never low; 3021 writes in order; exactly one sprite_done, coincident with address (y+56)*320+(x+52).
- Clipping: push (320,0), (0,240) and (319,239) → first two dropped with dropped_count=2; one write to address 76799.
- Transparency: with TRANSPARENT_EN=1, push colour 000 then 011, the 000 entry carrying last=1 → one write; sprite_done still pulses on the dropped entry.
- Backpressure: fb_hold=1 while pushing 6 beats → 4 accepted, in_ready=0, fifo_level=4. Release fb_hold → 4 consecutive writes in order; in_ready rises the cycle after the first pop.
- Reset with fifo_level=3 → outputs immediately at reset values; no further writes after deassert without new pushes.
